// File: rtl/alu_pkg.sv
// Shared definitions for iter_alu: op codes, FSM states and iteration counter sizing.
// The optional multiply/divide unit is enabled by defining ITER_ALU_MULDIV_EN.
package alu_pkg;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_MUL  = 3'b011;
    localparam logic [2:0] OP_DIVU = 3'b100;
    localparam logic [2:0] OP_REMU = 3'b101;
    localparam logic [2:0] OP_SUB  = 3'b110;
    localparam logic [2:0] OP_SLT  = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    // Counter must hold values up to WIDTH.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

    function automatic logic is_iter_op(input logic [2:0] op);
        case (op)
            OP_MUL, OP_DIVU, OP_REMU: is_iter_op = 1'b1;
            default:                  is_iter_op = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/iter_muldiv.sv
// Bit-serial unsigned multiply (shift-add) and restoring divide/remainder over WIDTH cycles.
// result is the combinational outcome of the final iteration, valid while done is high.
module iter_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = cnt_width(WIDTH);

    logic [CW-1:0]    cnt_r;
    logic             run_r;
    logic [2:0]       op_r;
    logic [WIDTH-1:0] acc_r;
    logic [WIDTH-1:0] mcand_r;
    logic [WIDTH-1:0] mplier_r;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH-1:0] dvsr_r;

    logic [WIDTH-1:0] acc_nx_s;
    logic [WIDTH:0]   shifted_s;
    logic [WIDTH:0]   diff_s;
    logic             ge_s;
    logic [WIDTH-1:0] rem_nx_s;
    logic [WIDTH-1:0] quo_nx_s;
    logic             last_s;

    // One iteration step; a zero divisor naturally yields all-ones quotient and remainder = dividend.
    always_comb begin
        acc_nx_s  = mplier_r[0] ? (acc_r + mcand_r) : acc_r;
        shifted_s = {rem_r, quo_r[WIDTH-1]};
        diff_s    = shifted_s - {1'b0, dvsr_r};
        ge_s      = (shifted_s >= {1'b0, dvsr_r});
        rem_nx_s  = ge_s ? diff_s[WIDTH-1:0] : shifted_s[WIDTH-1:0];
        quo_nx_s  = {quo_r[WIDTH-2:0], ge_s};
        last_s    = run_r && (cnt_r == CW'(WIDTH - 1));
    end

    // Result selection for the final iteration.
    always_comb begin
        result = rem_nx_s;
        case (op_r)
            OP_MUL:  result = acc_nx_s;
            OP_DIVU: result = quo_nx_s;
            default: result = rem_nx_s;
        endcase
    end

    assign done = last_s;

    // Operand capture on start, then one iteration per cycle until WIDTH are done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r    <= {CW{1'b0}};
            run_r    <= 1'b0;
            op_r     <= 3'b000;
            acc_r    <= {WIDTH{1'b0}};
            mcand_r  <= {WIDTH{1'b0}};
            mplier_r <= {WIDTH{1'b0}};
            rem_r    <= {WIDTH{1'b0}};
            quo_r    <= {WIDTH{1'b0}};
            dvsr_r   <= {WIDTH{1'b0}};
        end else if (start) begin
            cnt_r    <= {CW{1'b0}};
            run_r    <= 1'b1;
            op_r     <= op;
            acc_r    <= {WIDTH{1'b0}};
            mcand_r  <= a;
            mplier_r <= b;
            rem_r    <= {WIDTH{1'b0}};
            quo_r    <= a;
            dvsr_r   <= b;
        end else if (run_r) begin
            cnt_r    <= cnt_r + CW'(1);
            run_r    <= ~last_s;
            acc_r    <= acc_nx_s;
            mcand_r  <= {mcand_r[WIDTH-2:0], 1'b0};
            mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
            rem_r    <= rem_nx_s;
            quo_r    <= quo_nx_s;
        end else begin
            run_r    <= 1'b0;
        end
    end

endmodule

// File: rtl/iter_alu.sv
// Handshaked ALU: single-cycle ADD/SUB/AND/OR/SLT plus, when ITER_ALU_MULDIV_EN is
// defined, iterative MUL/DIVU/REMU taking WIDTH cycles. Without it those codes return 0.
module iter_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    input  logic [2:0]       ALU_control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALU_result,
    output logic             zero,
    output logic             busy
);

    state_t           state_r;
    state_t           state_nx_s;
    logic [WIDTH-1:0] result_r;
    logic [WIDTH-1:0] result_nx_s;
    logic             zero_r;
    logic [WIDTH-1:0] single_s;
    logic             in_ready_s;
    logic             accept_s;
    logic             iter_op_s;
    logic             md_done_s;
    logic [WIDTH-1:0] md_result_s;

`ifdef ITER_ALU_MULDIV_EN
    logic start_s;

    assign iter_op_s = is_iter_op(ALU_control);
    assign start_s   = accept_s && iter_op_s;

    iter_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start_s),
        .op     (ALU_control),
        .a      (srcA),
        .b      (srcB),
        .done   (md_done_s),
        .result (md_result_s)
    );
`else
    // BUSY is unreachable here; if ever entered it exits at once with a zero result.
    assign iter_op_s   = 1'b0;
    assign md_done_s   = 1'b1;
    assign md_result_s = {WIDTH{1'b0}};
`endif

    // Single-cycle datapath; unimplemented codes produce zero.
    always_comb begin
        single_s = {WIDTH{1'b0}};
        case (ALU_control)
            OP_ADD:  single_s = srcA + srcB;
            OP_SUB:  single_s = srcA - srcB;
            OP_AND:  single_s = srcA & srcB;
            OP_OR:   single_s = srcA | srcB;
            OP_SLT:  single_s = {{(WIDTH-1){1'b0}}, (srcA < srcB)};
            default: single_s = {WIDTH{1'b0}};
        endcase
    end

    // A DONE result being consumed frees the slot in the same cycle.
    always_comb begin
        in_ready_s = 1'b0;
        if (state_r == IDLE) begin
            in_ready_s = 1'b1;
        end else if (state_r == DONE) begin
            in_ready_s = out_ready;
        end else begin
            in_ready_s = 1'b0;
        end
        accept_s = in_valid && in_ready_s;
    end

    // Next-state and next-result logic.
    always_comb begin
        state_nx_s  = state_r;
        result_nx_s = result_r;
        case (state_r)
            IDLE, DONE: begin
                if (accept_s) begin
                    if (iter_op_s) begin
                        state_nx_s = BUSY;
                    end else begin
                        state_nx_s  = DONE;
                        result_nx_s = single_s;
                    end
                end else if ((state_r == DONE) && out_ready) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = state_r;
                end
            end
            BUSY: begin
                if (md_done_s) begin
                    state_nx_s  = DONE;
                    result_nx_s = md_result_s;
                end else begin
                    state_nx_s = BUSY;
                end
            end
            default: state_nx_s = IDLE;
        endcase
    end

    // State, result and zero-flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            result_r <= {WIDTH{1'b0}};
            zero_r   <= 1'b1;
        end else begin
            state_r  <= state_nx_s;
            result_r <= result_nx_s;
            zero_r   <= (result_nx_s == {WIDTH{1'b0}});
        end
    end

    assign in_ready   = in_ready_s;
    assign out_valid  = (state_r == DONE);
    assign ALU_result = result_r;
    assign zero       = zero_r;
`ifdef ITER_ALU_MULDIV_EN
    assign busy = (state_r == BUSY);
`else
    assign busy = 1'b0;
`endif

endmodule

// File: tb/tb_iter_alu.sv
// Directed self-checking bench for iter_alu (WIDTH=32); iterative tests run only when
// ITER_ALU_MULDIV_EN is defined, otherwise the disabled-code behaviour is checked.
module tb_iter_alu;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] srcA = '0;
    logic [W-1:0] srcB = '0;
    logic [2:0]   ALU_control = 3'b000;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] ALU_result;
    logic         zero;
    logic         busy;

    int   n_cmp = 0;
    int   n_bad = 0;
    logic busy_seen = 1'b0;

    iter_alu #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .srcA        (srcA),
        .srcB        (srcB),
        .ALU_control (ALU_control),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .ALU_result  (ALU_result),
        .zero        (zero),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (busy) busy_seen <= 1'b1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (ALU_result !== 32'h0) begin n_bad++; $display("FAIL reset_result: got %h want 0", ALU_result); end
        n_cmp++; if (zero !== 1'b1) begin n_bad++; $display("FAIL reset_zero: got %b want 1", zero); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [2:0]   ops [9] = '{3'b010, 3'b110, 3'b111, 3'b000, 3'b001, 3'b110, 3'b010, 3'b111, 3'b111};
        logic [W-1:0] av  [9] = '{32'd5, 32'd3, 32'd2, 32'hF0F0_1234, 32'h0000_00A0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5};
        logic [W-1:0] bv  [9] = '{32'd7, 32'd3, 32'hFFFF_FFFF, 32'h0FF0_FF00, 32'h0000_0005, 32'd1, 32'd2, 32'd2, 32'd5};
        logic [W-1:0] ev  [9] = '{32'd12, 32'd0, 32'd1, 32'h00F0_1200, 32'h0000_00A5, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0};
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            in_valid = 1'b1; ALU_control = ops[i]; srcA = av[i]; srcB = bv[i];
            @(posedge clk);
            @(negedge clk);
            n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_valid[%0d]: got %b want 1", i, out_valid); end
            n_cmp++; if (ALU_result !== ev[i]) begin n_bad++; $display("FAIL b2b_result[%0d]: got %h want %h", i, ALU_result, ev[i]); end
            n_cmp++; if (zero !== (ev[i] == 32'h0)) begin n_bad++; $display("FAIL b2b_zero[%0d]: got %b want %b", i, zero, (ev[i] == 32'h0)); end
            n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_in_ready[%0d]: got %b want 1", i, in_ready); end
        end
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid = 1'b1; ALU_control = 3'b010; srcA = 32'd10; srcB = 32'd20;
        @(posedge clk);
        @(negedge clk);
        // Held next op: must not be taken while the consumer stalls.
        ALU_control = 3'b001; srcA = 32'd1; srcB = 32'd2;
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_valid[%0d]: got %b want 1", i, out_valid); end
            n_cmp++; if (ALU_result !== 32'd30) begin n_bad++; $display("FAIL bp_result[%0d]: got %h want 1e", i, ALU_result); end
            n_cmp++; if (zero !== 1'b0) begin n_bad++; $display("FAIL bp_zero[%0d]: got %b want 0", i, zero); end
            n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, in_ready); end
            @(posedge clk);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_cmp++; if (ALU_result !== 32'd3) begin n_bad++; $display("FAIL bp_release_result: got %h want 3", ALU_result); end
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_release_valid: got %b want 1", out_valid); end
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset_in_done();
        int seen;
        seen = 0;
        out_ready = 1'b0;
        in_valid = 1'b1; ALU_control = 3'b010; srcA = 32'd1; srcB = 32'd1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rdone_valid: got %b want 0", out_valid); end
        n_cmp++; if (ALU_result !== 32'h0) begin n_bad++; $display("FAIL rdone_result: got %h want 0", ALU_result); end
        n_cmp++; if (zero !== 1'b1) begin n_bad++; $display("FAIL rdone_zero: got %b want 1", zero); end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL rdone_no_valid: got %0d valid cycles want 0", seen); end
    endtask

`ifdef ITER_ALU_MULDIV_EN
    task automatic run_iter(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] exp, input int id);
        int k;
        out_ready = 1'b1;
        in_valid = 1'b1; ALU_control = op; srcA = a; srcB = b;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; ALU_control = 3'b010; srcA = ~a; srcB = 32'd3;
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL iter_busy[%0d]: got %b want 1", id, busy); end
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL iter_in_ready[%0d]: got %b want 0", id, in_ready); end
        k = 1;
        while (!out_valid && k < 100) begin
            @(posedge clk);
            @(negedge clk);
            k++;
        end
        n_cmp++; if (k !== W + 1) begin n_bad++; $display("FAIL iter_latency[%0d]: got cycle N+%0d want N+%0d", id, k, W + 1); end
        n_cmp++; if (ALU_result !== exp) begin n_bad++; $display("FAIL iter_result[%0d]: got %h want %h", id, ALU_result, exp); end
        n_cmp++; if (zero !== (exp == 32'h0)) begin n_bad++; $display("FAIL iter_zero[%0d]: got %b want %b", id, zero, (exp == 32'h0)); end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_muldiv();
        run_iter(3'b011, 32'h0001_0000, 32'h0001_0000, 32'h0, 0);
        run_iter(3'b011, 32'd1234, 32'd5678, 32'd7006652, 1);
        run_iter(3'b100, 32'd100, 32'd7, 32'd14, 2);
        run_iter(3'b101, 32'd100, 32'd7, 32'd2, 3);
        run_iter(3'b100, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 4);
        run_iter(3'b101, 32'd9, 32'd0, 32'd9, 5);
        run_iter(3'b100, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 6);
        run_iter(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 7);
    endtask

    task automatic test_reset_abort();
        int seen;
        seen = 0;
        out_ready = 1'b1;
        in_valid = 1'b1; ALU_control = 3'b100; srcA = 32'd1000; srcB = 32'd3;
        @(posedge clk);
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b want 0", busy); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL abort_in_ready: got %b want 1", in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL abort_no_valid: got %0d valid cycles want 0", seen); end
    endtask
`else
    task automatic test_disabled_codes();
        logic [2:0] ops [3] = '{3'b011, 3'b100, 3'b101};
        out_ready = 1'b1;
        busy_seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; ALU_control = ops[i]; srcA = 32'd3; srcB = 32'd4;
            @(posedge clk);
            @(negedge clk);
            n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL dis_valid[%0d]: got %b want 1", i, out_valid); end
            n_cmp++; if (ALU_result !== 32'h0) begin n_bad++; $display("FAIL dis_result[%0d]: got %h want 0", i, ALU_result); end
            n_cmp++; if (zero !== 1'b1) begin n_bad++; $display("FAIL dis_zero[%0d]: got %b want 1", i, zero); end
        end
        // A non-zero single-cycle op in between proves the zero results are not stale.
        ALU_control = 3'b010;
        @(posedge clk);
        @(negedge clk);
        n_cmp++; if (ALU_result !== 32'd7) begin n_bad++; $display("FAIL dis_add: got %h want 7", ALU_result); end
        ALU_control = 3'b011; srcA = 32'd6; srcB = 32'd7;
        @(posedge clk);
        @(negedge clk);
        n_cmp++; if (ALU_result !== 32'h0) begin n_bad++; $display("FAIL dis_after_add: got %h want 0", ALU_result); end
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_cmp++; if (busy_seen !== 1'b0) begin n_bad++; $display("FAIL dis_busy_seen: got %b want 0", busy_seen); end
    endtask
`endif

    initial begin
        test_reset();
        test_back_to_back();
        test_backpressure();
        test_reset_in_done();
`ifdef ITER_ALU_MULDIV_EN
        test_muldiv();
        test_reset_abort();
`else
        test_disabled_codes();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
